dac_multi_ch: RTL and testbench

Parametrised serial DAC driver, the successor to the single-word `dac` block. It holds one shadow word per DAC channel and tracks which channels are dirty. On request, or automatically, it serialises every dirty word MSB-first over a 3-wire interface (cs_n, sclk, din). Words go out in ascending channel order, with a programmable SCLK rate and inter-frame gap. It sits between the application logic and the external DAC pins.

---
 rtl/dac_multi_ch.sv | 193 +++++++++++++++++++
 tb/tb_dac_multi_ch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_multi_ch.sv
// Multi-channel serial DAC driver: per-channel shadow words with dirty tracking,
// sent MSB-first over cs_n/sclk/din in ascending channel order.
module dac_multi_ch #(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 1,
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              auto_en,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   cur_ch
);

    localparam int unsigned CNT_MAX = (SCLK_DIV > GAP_CYC) ? SCLK_DIV : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(WORD_W);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StGap} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [CHANNELS-1:0] dirty_q, dirty_d;
    logic [WORD_W-1:0]   shadow_q [CHANNELS];

    logic                wr_valid;
    logic                any_dirty;
    logic                launch;
    logic [CH_W-1:0]     sel_ch;

    assign wr_valid  = wr_en && (32'(wr_ch) < CHANNELS);
    assign any_dirty = |dirty_q;

    // Descending scan so the lowest-index dirty channel wins.
    always_comb begin
        sel_ch = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                sel_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cur_ch_d  = cur_ch_q;
        launch    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start || (auto_en && any_dirty)) begin
                    if (any_dirty) begin
                        launch = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StHigh: begin
                if (div_cnt_q == CNT_W'(SCLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    state_d   = StLow;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (div_cnt_q == CNT_W'(SCLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    if (32'(bit_cnt_q) < WORD_W - 1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q << 1;
                        din_d     = shift_q[WORD_W-2];
                        state_d   = StHigh;
                    end else begin
                        cs_n_d  = 1'b1;
                        din_d   = 1'b0;
                        state_d = StGap;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (div_cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    div_cnt_d = '0;
                    if (any_dirty) begin
                        launch = 1'b1;
                    end else begin
                        state_d  = StIdle;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        cur_ch_d = '0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d   = StHigh;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = shadow_q[sel_ch];
            din_d     = shadow_q[sel_ch][WORD_W-1];
            cs_n_d    = 1'b0;
            sclk_d    = 1'b1;
            busy_d    = 1'b1;
            cur_ch_d  = sel_ch;
        end

        // A same-cycle write to the launching channel keeps it dirty.
        dirty_d = dirty_q;
        if (launch) begin
            dirty_d[sel_ch] = 1'b0;
        end
        if (wr_valid) begin
            dirty_d[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cur_ch_q  <= '0;
            dirty_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cur_ch_q  <= cur_ch_d;
            dirty_q   <= dirty_d;
            if (wr_valid) begin
                shadow_q[wr_ch] <= wr_data;
            end
        end
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_dac_multi_ch.sv
// Self-checking bench for dac_multi_ch: default-timing instance driven from a vector
// table plus directed sequences, and a fast instance for the auto_en path.
module tb_dac_multi_ch;

    logic clk = 1'b0;
    logic rst;

    logic        wr_en, start, auto_en;
    logic [0:0]  wr_ch;
    logic [15:0] wr_data;
    logic        cs_n1, sclk1, din1, busy1, done1;
    logic [0:0]  cur_ch1;

    logic        wr_en2, start2, auto_en2;
    logic [0:0]  wr_ch2;
    logic [15:0] wr_data2;
    logic        cs_n2, sclk2, din2, busy2, done2;
    logic [0:0]  cur_ch2;

    int checks = 0;
    int errors = 0;
    int glitches = 0;

    logic [15:0] fq_word[$];
    int          fq_ch[$];
    int          fq_falls[$];
    int          fq_low[$];

    always #10 clk = ~clk;

    dac_multi_ch dut (
        .clk_50mhz(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .start(start), .auto_en(auto_en), .dac_cs_n(cs_n1), .dac_sclk(sclk1),
        .dac_din(din1), .busy(busy1), .done(done1), .cur_ch(cur_ch1)
    );

    dac_multi_ch #(.SCLK_DIV(1), .GAP_CYC(1)) dut2 (
        .clk_50mhz(clk), .rst(rst), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_data(wr_data2),
        .start(start2), .auto_en(auto_en2), .dac_cs_n(cs_n2), .dac_sclk(sclk2),
        .dac_din(din2), .busy(busy2), .done(done2), .cur_ch(cur_ch2)
    );

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        int          exp_frames;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr1(input logic [0:0] ch, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after a trigger edge; lat counts edges from that edge to the done edge.
    task automatic run_until_done(input bit sel, output int lat, output logic busy_first);
        logic p_cs = 1'b1, p_sclk = 1'b1, p_din = 1'b0;
        logic cs, sc, dd, dn, bz;
        logic [15:0] w = '0;
        int falls = 0, low = 0, ch = 0, cyc = 0;
        bit got = 0;
        busy_first = 1'b0;
        fq_word.delete(); fq_ch.delete(); fq_falls.delete(); fq_low.delete();
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cs = sel ? cs_n2 : cs_n1;
            sc = sel ? sclk2 : sclk1;
            dd = sel ? din2  : din1;
            dn = sel ? done2 : done1;
            bz = sel ? busy2 : busy1;
            if (cyc == 1) busy_first = bz;
            if (!cs && p_cs) begin
                w = '0; falls = 0; low = 0;
                ch = sel ? int'(cur_ch2) : int'(cur_ch1);
            end
            if (!cs) low++;
            if (!cs && p_sclk && !sc) begin
                w = {w[14:0], dd};
                falls++;
            end
            if (cs && !p_cs) begin
                fq_word.push_back(w); fq_ch.push_back(ch);
                fq_falls.push_back(falls); fq_low.push_back(low);
            end
            if (dd != p_din && !(sc && !p_sclk) && !(!cs && p_cs)) glitches++;
            if (dn) got = 1;
            p_cs = cs; p_sclk = sc; p_din = dd;
        end
        lat = got ? cyc - 1 : -1;
    endtask

    initial begin
        int          lat;
        logic        bf;
        logic [15:0] ew[2];
        int          ec[2];
        int          n;
        bit          seen;

        vecs[0] = '{v0: 1'b1, d0: 16'hCAAA, v1: 1'b0, d1: 16'h0000, exp_frames: 1, exp_lat: 66};
        vecs[1] = '{v0: 1'b1, d0: 16'hC555, v1: 1'b1, d1: 16'h4555, exp_frames: 2, exp_lat: 132};
        vecs[2] = '{v0: 1'b0, d0: 16'h0000, v1: 1'b0, d1: 16'h0000, exp_frames: 0, exp_lat: 0};
        vecs[3] = '{v0: 1'b0, d0: 16'h0000, v1: 1'b1, d1: 16'h8001, exp_frames: 1, exp_lat: 66};

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; start = 1'b0; auto_en = 1'b0;
        wr_en2 = 1'b0; wr_ch2 = '0; wr_data2 = '0; start2 = 1'b0; auto_en2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", cs_n1, 1'b1);
        chk("rst_sclk", sclk1, 1'b1);
        chk("rst_din", din1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_cur_ch", cur_ch1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            n = 0;
            if (vecs[v].v1) wr1(1'b1, vecs[v].d1);
            if (vecs[v].v0) wr1(1'b0, vecs[v].d0);
            if (vecs[v].v0) begin ew[n] = vecs[v].d0; ec[n] = 0; n++; end
            if (vecs[v].v1) begin ew[n] = vecs[v].d1; ec[n] = 1; n++; end
            pulse_start();
            run_until_done(1'b0, lat, bf);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_busy_rise", v), bf, vecs[v].exp_frames > 0);
            chk($sformatf("v%0d_busy_fall", v), busy1, 1'b0);
            chk($sformatf("v%0d_cur_ch_idle", v), cur_ch1, 1'b0);
            chk($sformatf("v%0d_frames", v), fq_word.size(), vecs[v].exp_frames);
            for (int i = 0; i < n && i < fq_word.size(); i++) begin
                chk($sformatf("v%0d_f%0d_word", v, i), fq_word[i], ew[i]);
                chk($sformatf("v%0d_f%0d_ch", v, i), fq_ch[i], ec[i]);
                chk($sformatf("v%0d_f%0d_falls", v, i), fq_falls[i], 16);
                chk($sformatf("v%0d_f%0d_cs_low", v, i), fq_low[i], 64);
            end
            @(posedge clk);
            #1;
        end

        // Rewrite of ch0 while its frame is in flight.
        wr1(1'b0, 16'hC555);
        pulse_start();
        fork
            run_until_done(1'b0, lat, bf);
            begin
                repeat (10) @(posedge clk);
                #1 wr1(1'b0, 16'h1234);
            end
        join
        chk("wb_latency", lat, 132);
        chk("wb_frames", fq_word.size(), 2);
        if (fq_word.size() == 2) begin
            chk("wb_f0_word", fq_word[0], 16'hC555);
            chk("wb_f1_word", fq_word[1], 16'h1234);
            chk("wb_f1_ch", fq_ch[1], 0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of bit 7 aborts the frame and clears dirty state.
        wr1(1'b0, 16'hCAAA);
        wr1(1'b1, 16'h4555);
        pulse_start();
        repeat (30) @(posedge clk);
        #1;
        chk("mid_cs_low", cs_n1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs_n", cs_n1, 1'b1);
        chk("abort_sclk", sclk1, 1'b1);
        chk("abort_din", din1, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_done", done1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done1) seen = 1;
        end
        chk("abort_no_done", seen, 1'b0);
        @(posedge clk);
        #1;
        pulse_start();
        run_until_done(1'b0, lat, bf);
        chk("post_rst_latency", lat, 0);
        chk("post_rst_frames", fq_word.size(), 0);
        chk("post_rst_busy", bf, 1'b0);

        // auto_en on the fast instance: launch one edge after the write, 33-cycle frame.
        @(posedge clk);
        #1;
        auto_en2 = 1'b1;
        wr_en2 = 1'b1; wr_ch2 = 1'b1; wr_data2 = 16'h8001;
        @(posedge clk);
        #1 wr_en2 = 1'b0;
        run_until_done(1'b1, lat, bf);
        chk("auto_idle_at_write", bf, 1'b0);
        chk("auto_latency", lat, 34);
        chk("auto_frames", fq_word.size(), 1);
        if (fq_word.size() == 1) begin
            chk("auto_word", fq_word[0], 16'h8001);
            chk("auto_ch", fq_ch[0], 1);
            chk("auto_falls", fq_falls[0], 16);
            chk("auto_cs_low", fq_low[0], 32);
        end
        chk("din_stability", glitches, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
